// File: rtl/cook_timer_pkg.sv
// Shared definitions for the multi-channel cook timer.
//   ch_state_t  : channel state encoding (IDLE=0, RUN=1, PAUSE=2, ALARM=3)
//   SEC_PER_MIN : seconds per minute, used for the carry and borrow logic
package cook_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } ch_state_t;

  localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/cook_timer_channel.sv
// One cook-timer channel: state machine, min:sec time registers and the
// alarm auto-off down-counter.
//   clk, reset_p              : clock and synchronous active-high reset
//   tick                      : shared 1 s pulse
//   ev_clear, ev_add, ev_sp   : button events already qualified for this channel
//   min, sec                  : current time of the channel
//   in_alarm, in_run          : unregistered state flags, registered in the top
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | stopped, time may be set with add
// ST_RUN   | counting down on each tick
// ST_PAUSE | counting suspended, time held
// ST_ALARM | reached 0:00, auto-off counter running on ticks
module cook_timer_channel
  import cook_timer_pkg::*;
#(
  parameter int STEP_SEC  = 30,
  parameter int MAX_MIN   = 5,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick,
  input  logic       ev_clear,
  input  logic       ev_add,
  input  logic       ev_sp,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       in_alarm,
  output logic       in_run
);

  localparam int              AW         = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [AW-1:0]   ALARM_LOAD = AW'(ALARM_SEC);
  localparam logic [7:0]      STEP       = 8'(STEP_SEC);
  localparam logic [7:0]      MAXM       = 8'(MAX_MIN);
  localparam logic [7:0]      SPM        = 8'(SEC_PER_MIN);
  localparam logic [7:0]      LAST_SEC   = 8'(SEC_PER_MIN - 1);

  ch_state_t     state;
  logic [AW-1:0] acnt;

  logic [7:0] sum_sec, add_sec, add_min;
  logic [7:0] dec_sec, dec_min;
  logic       dec_zero, time_zero;

  always_comb begin
    sum_sec = sec + STEP;
    if (sum_sec >= SPM) begin
      add_sec = sum_sec - SPM;
      add_min = min + 8'd1;
    end else begin
      add_sec = sum_sec;
      add_min = min;
    end
    if (add_min >= MAXM) begin
      add_min = MAXM;
      add_sec = 8'd0;
    end

    if (sec == 8'd0) begin
      dec_sec = LAST_SEC;
      dec_min = min - 8'd1;
    end else begin
      dec_sec = sec - 8'd1;
      dec_min = min;
    end
    dec_zero  = (dec_min == 8'd0) && (dec_sec == 8'd0);
    time_zero = (min == 8'd0) && (sec == 8'd0);
  end

  // Button events are checked before the tick, so a tick landing on an
  // event cycle is simply dropped for this channel.
  always_ff @(posedge clk) begin
    if (reset_p || ev_clear) begin
      state <= ST_IDLE;
      min   <= 8'd0;
      sec   <= 8'd0;
      acnt  <= '0;
    end else if (ev_add) begin
      if (state == ST_ALARM) begin
        state <= ST_IDLE;
        min   <= 8'd0;
        sec   <= STEP;
        acnt  <= '0;
      end else begin
        min <= add_min;
        sec <= add_sec;
      end
    end else if (ev_sp) begin
      case (state)
        ST_IDLE:  if (!time_zero) state <= ST_RUN;
        ST_RUN:   state <= ST_PAUSE;
        ST_PAUSE: state <= ST_RUN;
        ST_ALARM: begin
          state <= ST_IDLE;
          acnt  <= '0;
        end
        default:  state <= ST_IDLE;
      endcase
    end else if (tick) begin
      if (state == ST_RUN) begin
        min <= dec_min;
        sec <= dec_sec;
        if (dec_zero) begin
          state <= ST_ALARM;
          acnt  <= ALARM_LOAD;
        end
      end else if (state == ST_ALARM && ALARM_SEC != 0) begin
        if (acnt == AW'(1)) begin
          state <= ST_IDLE;
          acnt  <= '0;
        end else begin
          acnt <= acnt - AW'(1);
        end
      end
    end
  end

  assign in_alarm = (state == ST_ALARM);
  assign in_run   = (state == ST_RUN);

endmodule

// File: rtl/edge_detector_p.sv
// Rising-edge detector for a debounced button level.
//   clk, reset_p : clock and synchronous active-high reset
//   level        : debounced button level
//   pulse        : high for one cycle in the cycle where level first reads 1
module edge_detector_p (
  input  logic clk,
  input  logic reset_p,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset_p) level_q <= 1'b0;
    else         level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/multi_cook_timer.sv
// Multi-channel kitchen cook timer.
//   clk, reset_p                        : clock and synchronous active-high reset
//   btn_start_pause, btn_add, btn_clear : debounced button levels
//   ch_sel                              : channel targeted by buttons and shown on min/sec
//   min, sec                            : registered time of channel ch_sel
//   alarm, running                      : registered per-channel ALARM / RUN flags
module multi_cook_timer
  import cook_timer_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int TICK_DIV  = 100_000_000,
  parameter int STEP_SEC  = 30,
  parameter int MAX_MIN   = 5,
  parameter int ALARM_SEC = 10
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic                   btn_start_pause,
  input  logic                   btn_add,
  input  logic                   btn_clear,
  input  logic [$clog2(NCH)-1:0] ch_sel,
  output logic [7:0]             min,
  output logic [7:0]             sec,
  output logic [NCH-1:0]         alarm,
  output logic [NCH-1:0]         running
);

  localparam int            SW        = $clog2(NCH);
  localparam int            PW        = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] TICK_LOAD = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          ev_sp, ev_add, ev_clear;

  logic [7:0]     ch_min [NCH];
  logic [7:0]     ch_sec [NCH];
  logic [NCH-1:0] ch_alarm, ch_run;

  // Free-running down-counter; terminal count produces the tick and reloads.
  assign tick = (pre_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset_p || tick) pre_cnt <= TICK_LOAD;
    else                 pre_cnt <= pre_cnt - PW'(1);
  end

  edge_detector_p u_ed_sp  (.clk(clk), .reset_p(reset_p), .level(btn_start_pause), .pulse(ev_sp));
  edge_detector_p u_ed_add (.clk(clk), .reset_p(reset_p), .level(btn_add),         .pulse(ev_add));
  edge_detector_p u_ed_clr (.clk(clk), .reset_p(reset_p), .level(btn_clear),       .pulse(ev_clear));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = (ch_sel == SW'(i));

    cook_timer_channel #(
      .STEP_SEC (STEP_SEC),
      .MAX_MIN  (MAX_MIN),
      .ALARM_SEC(ALARM_SEC)
    ) u_ch (
      .clk     (clk),
      .reset_p (reset_p),
      .tick    (tick),
      .ev_clear(ev_clear & hit),
      .ev_add  (ev_add & hit),
      .ev_sp   (ev_sp & hit),
      .min     (ch_min[i]),
      .sec     (ch_sec[i]),
      .in_alarm(ch_alarm[i]),
      .in_run  (ch_run[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      min     <= 8'd0;
      sec     <= 8'd0;
      alarm   <= '0;
      running <= '0;
    end else begin
      min     <= ch_min[ch_sel];
      sec     <= ch_sec[ch_sel];
      alarm   <= ch_alarm;
      running <= ch_run;
    end
  end

endmodule
